id_pipe: RTL and testbench

ID_PIPE -- requirements
Module: id_pipe

---
 rtl/id_pipe_if.sv | 33 +++
 rtl/id_pipe.sv | 191 +++++++++++++++++++
 tb/tb_id_pipe.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/id_pipe_if.sv
// Fetch->ID and ID->EX handshake plus the registered ID/EX fields.
interface id_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       pc_i;
  logic [31:0]       inst_i;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       pc_o;
  logic [7:0]        aluop_o;
  logic [2:0]        alusel_o;
  logic [DATA_W-1:0] reg1_o;
  logic [DATA_W-1:0] reg2_o;
  logic [ADDR_W-1:0] wd_o;
  logic              wreg_o;
  logic              is_load_o;
  logic              inst_invalid_o;

  modport slave (
    input  in_valid, pc_i, inst_i, out_ready,
    output in_ready, out_valid, pc_o, aluop_o, alusel_o, reg1_o, reg2_o,
           wd_o, wreg_o, is_load_o, inst_invalid_o
  );

  modport master (
    output in_valid, pc_i, inst_i, out_ready,
    input  in_ready, out_valid, pc_o, aluop_o, alusel_o, reg1_o, reg2_o,
           wd_o, wreg_o, is_load_o, inst_invalid_o
  );
endinterface

// File: rtl/id_pipe.sv
// Instruction decode stage: decode, operand bypass, load-use stall, ID/EX register.
module id_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  id_pipe_if.slave                  bus,
  input  logic                      flush,
  output logic [ADDR_W-1:0]         reg1_addr_o,
  output logic [ADDR_W-1:0]         reg2_addr_o,
  output logic                      reg1_read_o,
  output logic                      reg2_read_o,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]          stall_cnt
);
  localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP = 8'b0010_0111;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [2:0] EXE_RES_NOP        = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [2:0] EXE_RES_LOAD_STORE = 3'b111;

  typedef enum logic {RUN, LU_STALL} state_t;
  state_t state, nxt;

  logic [5:0]        op, funct;
  logic [4:0]        shamt;
  logic [15:0]       imm16;
  logic [ADDR_W-1:0] rs, rt, rd;
  logic [7:0]        aluop;
  logic [2:0]        alusel;
  logic              rd1_en, rd2_en, wreg, is_load, invalid;
  logic [ADDR_W-1:0] wd;
  logic [DATA_W-1:0] imm, opnd1, opnd2;
  logic              advance, hazard, take, stall_go;

  assign op    = bus.inst_i[31:26];
  assign rs    = ADDR_W'(bus.inst_i[25:21]);
  assign rt    = ADDR_W'(bus.inst_i[20:16]);
  assign rd    = ADDR_W'(bus.inst_i[15:11]);
  assign shamt = bus.inst_i[10:6];
  assign funct = bus.inst_i[5:0];
  assign imm16 = bus.inst_i[15:0];

  always_comb begin
    aluop   = EXE_NOP_OP;
    alusel  = EXE_RES_NOP;
    rd1_en  = 1'b0;
    rd2_en  = 1'b0;
    wreg    = 1'b0;
    wd      = '0;
    imm     = '0;
    is_load = 1'b0;
    invalid = 1'b1;
    case (op)
      6'b001101, 6'b001100, 6'b001110: begin
        aluop   = (op == 6'b001101) ? EXE_OR_OP : (op == 6'b001100) ? EXE_AND_OP : EXE_XOR_OP;
        alusel  = EXE_RES_LOGIC;
        rd1_en  = 1'b1;
        imm     = DATA_W'(imm16);
        wreg    = 1'b1;
        wd      = rt;
        invalid = 1'b0;
      end
      6'b001111: begin
        // No reads: both operands carry the shifted immediate, OR yields it unchanged
        aluop   = EXE_OR_OP;
        alusel  = EXE_RES_LOGIC;
        imm     = DATA_W'({imm16, 16'h0000});
        wreg    = 1'b1;
        wd      = rt;
        invalid = 1'b0;
      end
      6'b100011: begin
        aluop   = EXE_LW_OP;
        alusel  = EXE_RES_LOAD_STORE;
        rd1_en  = 1'b1;
        imm     = {{(DATA_W-16){imm16[15]}}, imm16};
        wreg    = 1'b1;
        wd      = rt;
        is_load = 1'b1;
        invalid = 1'b0;
      end
      6'b000000: begin
        if (shamt == 5'd0 && funct[5:2] == 4'b1001) begin
          case (funct[1:0])
            2'b00:   aluop = EXE_AND_OP;
            2'b01:   aluop = EXE_OR_OP;
            2'b10:   aluop = EXE_XOR_OP;
            default: aluop = EXE_NOR_OP;
          endcase
          alusel  = EXE_RES_LOGIC;
          rd1_en  = 1'b1;
          rd2_en  = 1'b1;
          wreg    = 1'b1;
          wd      = rd;
          invalid = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign reg1_addr_o = rs;
  assign reg2_addr_o = rt;
  assign reg1_read_o = bus.in_valid && rd1_en;
  assign reg2_read_o = bus.in_valid && rd2_en;

  // Scan from the lowest-priority source up so the lowest index wins
  always_comb begin
    opnd1 = reg1_data_i;
    opnd2 = reg2_data_i;
    for (int k = NUM_FWD-1; k >= 0; k--) begin
      if (fwd_we[k] && fwd_addr[k*ADDR_W +: ADDR_W] == rs) opnd1 = fwd_data[k*DATA_W +: DATA_W];
      if (fwd_we[k] && fwd_addr[k*ADDR_W +: ADDR_W] == rt) opnd2 = fwd_data[k*DATA_W +: DATA_W];
    end
    if (!rd1_en)         opnd1 = imm;
    else if (rs == '0)   opnd1 = '0;
    if (!rd2_en)         opnd2 = imm;
    else if (rt == '0)   opnd2 = '0;
  end

  assign advance = !bus.out_valid || bus.out_ready;
  assign hazard  = bus.out_valid && bus.is_load_o && bus.wreg_o && bus.wd_o != '0 &&
                   ((rd1_en && rs == bus.wd_o) || (rd2_en && rt == bus.wd_o)) && bus.in_valid;
  assign bus.in_ready = advance && !hazard && !flush;
  assign take         = bus.in_valid && bus.in_ready;

  always_comb begin
    nxt      = state;
    stall_go = 1'b0;
    case (state)
      RUN: if (!flush && hazard && advance) begin
        nxt      = LU_STALL;
        stall_go = 1'b1;
      end
      default: nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      stall_cnt <= '0;
    end else begin
      state <= nxt;
      if (stall_go && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.out_valid      <= 1'b0;
      bus.pc_o           <= '0;
      bus.aluop_o        <= EXE_NOP_OP;
      bus.alusel_o       <= EXE_RES_NOP;
      bus.reg1_o         <= '0;
      bus.reg2_o         <= '0;
      bus.wd_o           <= '0;
      bus.wreg_o         <= 1'b0;
      bus.is_load_o      <= 1'b0;
      bus.inst_invalid_o <= 1'b0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (advance) begin
      // A stall cycle lands here with take=0 and becomes the bubble
      bus.out_valid <= take;
      if (take) begin
        bus.pc_o           <= bus.pc_i;
        bus.aluop_o        <= aluop;
        bus.alusel_o       <= alusel;
        bus.reg1_o         <= opnd1;
        bus.reg2_o         <= opnd2;
        bus.wd_o           <= wd;
        bus.wreg_o         <= wreg;
        bus.is_load_o      <= is_load;
        bus.inst_invalid_o <= invalid;
      end
    end
  end
endmodule

// File: tb/tb_id_pipe.sv
// Directed bench for id_pipe: decode, bypass priority, load-use stall, backpressure, flush, reset.
module tb_id_pipe;
  localparam int DW = 32, AW = 5, NF = 2, CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  id_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  logic [AW-1:0]    reg1_addr_o, reg2_addr_o;
  logic             reg1_read_o, reg2_read_o;
  logic [DW-1:0]    reg1_data_i, reg2_data_i;
  logic [NF-1:0]    fwd_we = '0;
  logic [NF*AW-1:0] fwd_addr = '0;
  logic [NF*DW-1:0] fwd_data = '0;
  logic [CW-1:0]    stall_cnt;

  function automatic logic [31:0] rf(input logic [4:0] a);
    return 32'h1000_0000 | 32'(a);
  endfunction
  assign reg1_data_i = rf(reg1_addr_o);
  assign reg2_data_i = rf(reg2_addr_o);

  id_pipe #(.DATA_W(DW), .ADDR_W(AW), .NUM_FWD(NF), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .flush(flush),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .stall_cnt(stall_cnt)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    bus.in_valid = v;
    bus.pc_i     = pc;
    bus.inst_i   = inst;
  endtask

  task automatic setfwd(input int k, input logic we, input logic [4:0] a, input logic [31:0] d);
    fwd_we[k]            = we;
    fwd_addr[k*AW +: AW] = a;
    fwd_data[k*DW +: DW] = d;
  endtask

  // LW $4,-4($5) then OR $6,$4,$4: leaves the stage in its stall cycle
  task automatic stall_seq(input logic [31:0] exp_cnt);
    drive(1'b1, 32'h200, itype(6'h23, 5'd5, 5'd4, 16'hFFFC));
    tick;
    chk("lw_is_load", bus.is_load_o, 1'b1);
    drive(1'b1, 32'h204, rtype(5'd4, 5'd4, 5'd6, 6'h25));
    #1 chk("lu_in_ready", bus.in_ready, 1'b0);
    tick;
    chk("lu_bubble", bus.out_valid, 1'b0);
    chk("lu_cnt", stall_cnt, exp_cnt);
  endtask

  task automatic stall_finish;
    setfwd(1, 1'b1, 5'd4, 32'h55);
    #1 chk("post_stall_ready", bus.in_ready, 1'b1);
    tick;
    chk("or_valid", bus.out_valid, 1'b1);
    chk("or_reg1_mem", bus.reg1_o, 32'h55);
    chk("or_reg2_mem", bus.reg2_o, 32'h55);
    chk("or_wd", bus.wd_o, 5'd6);
    setfwd(1, 1'b0, 5'd0, 32'h0);
    drive(1'b0, 32'h0, 32'h0);
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    bus.out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    tick;
    tick;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_pc", bus.pc_o, 0);
    chk("rst_aluop", bus.aluop_o, 8'h00);
    chk("rst_alusel", bus.alusel_o, 3'h0);
    chk("rst_reg1", bus.reg1_o, 0);
    chk("rst_reg2", bus.reg2_o, 0);
    chk("rst_wd", bus.wd_o, 0);
    chk("rst_wreg", bus.wreg_o, 1'b0);
    chk("rst_load", bus.is_load_o, 1'b0);
    chk("rst_inv", bus.inst_invalid_o, 1'b0);
    rst = 1'b1;
    #1 chk("idle_ready", bus.in_ready, 1'b1);
    chk("idle_read", reg1_read_o, 1'b0);

    // ORI $1,$0,0x1100
    drive(1'b1, 32'h100, 32'h3401_1100);
    #1 chk("ori_rd1", reg1_read_o, 1'b1);
    chk("ori_rd2", reg2_read_o, 1'b0);
    tick;
    chk("ori_valid", bus.out_valid, 1'b1);
    chk("ori_reg1", bus.reg1_o, 0);
    chk("ori_reg2", bus.reg2_o, 32'h1100);
    chk("ori_wd", bus.wd_o, 5'd1);
    chk("ori_wreg", bus.wreg_o, 1'b1);
    chk("ori_aluop", bus.aluop_o, 8'h25);
    chk("ori_alusel", bus.alusel_o, 3'h1);
    chk("ori_pc", bus.pc_o, 32'h100);

    // OR $3,$1,$2: both sources match $1, fwd0 wins
    drive(1'b1, 32'h104, rtype(5'd1, 5'd2, 5'd3, 6'h25));
    setfwd(0, 1'b1, 5'd1, 32'hA);
    setfwd(1, 1'b1, 5'd1, 32'hB);
    tick;
    chk("prio_reg1", bus.reg1_o, 32'hA);
    chk("prio_reg2_rf", bus.reg2_o, 32'h1000_0002);
    chk("prio_wd", bus.wd_o, 5'd3);
    setfwd(1, 1'b1, 5'd2, 32'hC);
    drive(1'b1, 32'h108, rtype(5'd1, 5'd2, 5'd3, 6'h25));
    tick;
    chk("fwd_reg1", bus.reg1_o, 32'hA);
    chk("fwd_reg2", bus.reg2_o, 32'hC);
    chk("fwd_pc", bus.pc_o, 32'h108);
    setfwd(0, 1'b0, 5'd0, 32'h0);
    setfwd(1, 1'b0, 5'd0, 32'h0);

    drive(1'b1, 32'h10C, itype(6'h0C, 5'd2, 5'd10, 16'h8001));
    tick;
    chk("andi_reg1", bus.reg1_o, 32'h1000_0002);
    chk("andi_zext", bus.reg2_o, 32'h0000_8001);
    chk("andi_aluop", bus.aluop_o, 8'h24);
    drive(1'b1, 32'h110, itype(6'h0F, 5'd0, 5'd11, 16'hABCD));
    tick;
    chk("lui_reg1", bus.reg1_o, 32'hABCD_0000);
    chk("lui_reg2", bus.reg2_o, 32'hABCD_0000);
    chk("lui_wd", bus.wd_o, 5'd11);
    drive(1'b1, 32'h114, rtype(5'd1, 5'd2, 5'd12, 6'h27));
    tick;
    chk("nor_reg1", bus.reg1_o, 32'h1000_0001);
    chk("nor_reg2", bus.reg2_o, 32'h1000_0002);
    chk("nor_aluop", bus.aluop_o, 8'h27);
    drive(1'b0, 32'h0, 32'h0);
    tick;
    chk("drain_valid", bus.out_valid, 1'b0);

    stall_seq(1);
    chk("lu_pc_held", bus.pc_o, 32'h200);
    stall_finish;

    drive(1'b1, 32'h300, itype(6'h0D, 5'd0, 5'd8, 16'h0008));
    tick;
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h304, itype(6'h0E, 5'd0, 5'd9, 16'h0009));
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", bus.in_ready, 1'b0);
      tick;
      chk("bp_valid", bus.out_valid, 1'b1);
      chk("bp_wd", bus.wd_o, 5'd8);
      chk("bp_pc", bus.pc_o, 32'h300);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_resume_ready", bus.in_ready, 1'b1);
    tick;
    chk("bp_next_wd", bus.wd_o, 5'd9);
    chk("bp_next_reg2", bus.reg2_o, 32'h9);
    chk("bp_next_aluop", bus.aluop_o, 8'h26);
    drive(1'b0, 32'h0, 32'h0);
    tick;
    chk("bp_drain", bus.out_valid, 1'b0);

    drive(1'b1, 32'h400, 32'h3401_1100);
    tick;
    flush = 1'b1;
    drive(1'b1, 32'h404, 32'h3402_2200);
    #1 chk("flush_ready", bus.in_ready, 1'b0);
    tick;
    chk("flush_valid", bus.out_valid, 1'b0);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick;

    // writes aimed at $0 never reach an operand
    setfwd(0, 1'b1, 5'd0, 32'hFFFF);
    drive(1'b1, 32'h500, rtype(5'd0, 5'd0, 5'd7, 6'h25));
    tick;
    chk("zero_reg1", bus.reg1_o, 0);
    chk("zero_reg2", bus.reg2_o, 0);
    chk("zero_wd", bus.wd_o, 5'd7);
    setfwd(0, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 32'h504, 32'hFC00_0000);
    tick;
    chk("inv_valid", bus.out_valid, 1'b1);
    chk("inv_flag", bus.inst_invalid_o, 1'b1);
    chk("inv_wreg", bus.wreg_o, 1'b0);
    chk("inv_aluop", bus.aluop_o, 8'h00);
    drive(1'b0, 32'h0, 32'h0);
    tick;

    stall_seq(2);
    flush = 1'b1;
    #1 chk("lu_flush_ready", bus.in_ready, 1'b0);
    tick;
    flush = 1'b0;
    chk("lu_flush_valid", bus.out_valid, 1'b0);
    #1 chk("lu_flush_no_bubble", bus.in_ready, 1'b1);
    drive(1'b0, 32'h0, 32'h0);
    tick;

    stall_seq(3);
    stall_finish;
    stall_seq(3);
    drive(1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    tick;
    chk("midrst_valid", bus.out_valid, 1'b0);
    chk("midrst_cnt", stall_cnt, 0);
    rst = 1'b1;
    drive(1'b1, 32'h600, 32'h3401_1100);
    #1 chk("midrst_ready", bus.in_ready, 1'b1);
    tick;
    chk("midrst_accept", bus.out_valid, 1'b1);
    chk("midrst_pc", bus.pc_o, 32'h600);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
